// File: rtl/ps2_cmd_sequencer.sv
// PS/2 set-2 command sequencer: parses E0/F0 prefixed byte streams, looks up each
// make code through an external combinational decoder, suppresses held-key repeats
// and queues the resulting 4-bit commands in a small valid/ready FIFO.
// Optional build macro: PS2_TYPEMATIC_EN (repeat make codes push their command again).
module ps2_cmd_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       byteValid,
    input  logic [7:0] byteData,
    output logic       byteReady,
    output logic [7:0] decCode,
    input  logic [3:0] decResult,
    output logic       cmdValid,
    output logic [3:0] cmdCode,
    input  logic       cmdReady,
    output logic       overflow,
    output logic       seqError
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TmrW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

`ifdef PS2_TYPEMATIC_EN
    localparam bit Typematic = 1'b1;
`else
    localparam bit Typematic = 1'b0;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StExt,
        StBrk,
        StExtBrk,
        StLookup
    } state_e;

    state_e          state_q;
    logic [7:0]      dec_code_q;
    logic            held_valid_q;
    logic [7:0]      held_code_q;
    logic [TmrW-1:0] tmr_q;
    logic            seq_err_q;
    logic            ovf_q;

    logic [3:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [CntW-1:0] cnt_q;

    logic byte_acc;
    logic tmr_expired;
    logic is_repeat;
    logic lookup_take;
    logic fifo_full;
    logic pop;
    logic push_ok;

    // Handshake and lookup decisions derived from registered state.
    always_comb begin
        byte_acc    = byteValid && (state_q != StLookup);
        tmr_expired = (tmr_q == TmrW'(TIMEOUT - 1));
        is_repeat   = held_valid_q && (dec_code_q == held_code_q);
        lookup_take = (state_q == StLookup) && (decResult != 4'hF) && (!is_repeat || Typematic);
        fifo_full   = (cnt_q == CntW'(FIFO_DEPTH));
        pop         = (cnt_q != '0) && cmdReady;
        // A full FIFO still accepts when the head is popped in the same cycle.
        push_ok     = lookup_take && (!fifo_full || pop);
    end

    assign byteReady = (state_q != StLookup);
    assign decCode   = dec_code_q;
    assign cmdValid  = (cnt_q != '0);
    assign cmdCode   = cmdValid ? mem_q[rd_ptr_q] : 4'h0;
    assign overflow  = ovf_q;
    assign seqError  = seq_err_q;

    // Byte-stream parser, prefix timer and held-key tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            dec_code_q   <= 8'h00;
            held_valid_q <= 1'b0;
            held_code_q  <= 8'h00;
            tmr_q        <= '0;
            seq_err_q    <= 1'b0;
        end else begin
            seq_err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    tmr_q <= '0;
                    if (byte_acc) begin
                        if (byteData == 8'hE0) begin
                            state_q <= StExt;
                        end else if (byteData == 8'hF0) begin
                            state_q <= StBrk;
                        end else begin
                            dec_code_q <= byteData;
                            state_q    <= StLookup;
                        end
                    end
                end
                StExt: begin
                    if (byte_acc) begin
                        tmr_q <= '0;
                        if (byteData == 8'hF0) begin
                            state_q <= StExtBrk;
                        end else if (byteData == 8'hE0) begin
                            seq_err_q <= 1'b1;
                        end else begin
                            // The E0 prefix is dropped: extended keys share base-code commands.
                            dec_code_q <= byteData;
                            state_q    <= StLookup;
                        end
                    end else if (tmr_expired) begin
                        tmr_q     <= '0;
                        seq_err_q <= 1'b1;
                        state_q   <= StIdle;
                    end else begin
                        tmr_q <= tmr_q + TmrW'(1);
                    end
                end
                StBrk, StExtBrk: begin
                    if (byte_acc) begin
                        tmr_q   <= '0;
                        state_q <= StIdle;
                        if (held_valid_q && (byteData == held_code_q)) begin
                            held_valid_q <= 1'b0;
                        end
                    end else if (tmr_expired) begin
                        tmr_q     <= '0;
                        seq_err_q <= 1'b1;
                        state_q   <= StIdle;
                    end else begin
                        tmr_q <= tmr_q + TmrW'(1);
                    end
                end
                StLookup: begin
                    tmr_q   <= '0;
                    state_q <= StIdle;
                    if (lookup_take) begin
                        held_code_q  <= dec_code_q;
                        held_valid_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // FIFO pointers, occupancy and the overflow pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            ovf_q <= lookup_take && fifo_full && !pop;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push_ok && !pop) begin
                cnt_q <= cnt_q + CntW'(1);
            end else if (pop && !push_ok) begin
                cnt_q <= cnt_q - CntW'(1);
            end
        end
    end

    // FIFO storage; contents are don't-care while empty so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= decResult;
        end
    end

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Scoreboard bench for ps2_cmd_sequencer: directed scenarios plus a randomized byte
// stream, all checked against a byte-level reference model of the key protocol.
module tb_ps2_cmd_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TO    = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       byteValid = 1'b0;
    logic [7:0] byteData = 8'h00;
    logic       byteReady;
    logic [7:0] decCode;
    logic [3:0] decResult;
    logic       cmdValid;
    logic [3:0] cmdCode;
    logic       cmdReady = 1'b0;
    logic       overflow;
    logic       seqError;

    always #5 clk = ~clk;

    ps2_cmd_sequencer #(
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT   (TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .byteValid(byteValid),
        .byteData (byteData),
        .byteReady(byteReady),
        .decCode  (decCode),
        .decResult(decResult),
        .cmdValid (cmdValid),
        .cmdCode  (cmdCode),
        .cmdReady (cmdReady),
        .overflow (overflow),
        .seqError (seqError)
    );

    // Stand-in for the scan-code decoder.
    function automatic logic [3:0] dec_ref(input logic [7:0] c);
        case (c)
            8'h16: return 4'h0;
            8'h1E: return 4'h1;
            8'h26: return 4'h2;
            8'h25: return 4'h3;
            8'h2D: return 4'h4;
            8'h34: return 4'h5;
            8'h32: return 4'h6;
            8'h75: return 4'h7;
            8'h43: return 4'hD;
            8'h2B: return 4'hE;
            default: return 4'hF;
        endcase
    endfunction

    always_comb decResult = dec_ref(decCode);

    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] exp_q[$];
    int exp_ovf = 0, exp_seq = 0, ovf_seen = 0, seq_seen = 0;
    int m_mode = 0;  // 0 none, 1 after E0, 2 after F0, 3 after E0 F0
    bit m_hv = 1'b0;
    logic [7:0] m_hc = 8'h00;
    bit mon_en = 1'b0;
    bit rand_ready = 1'b0;
    logic [3:0] mon_exp;
    logic [7:0] pool [14] = '{8'hE0, 8'hF0, 8'h16, 8'h1E, 8'h26, 8'h2D, 8'h34,
                              8'h32, 8'h75, 8'h43, 8'h2B, 8'h1C, 8'h1E, 8'h75};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_push(input logic [3:0] r);
        if (exp_q.size() >= DEPTH) exp_ovf++;
        else exp_q.push_back(r);
    endtask

    task automatic model_make(input logic [7:0] b);
        logic [3:0] r;
        r = dec_ref(b);
        if (r == 4'hF) return;
        if (m_hv && b == m_hc) begin
`ifdef PS2_TYPEMATIC_EN
            model_push(r);
`endif
            return;
        end
        model_push(r);
        m_hv = 1'b1;
        m_hc = b;
    endtask

    task automatic model_byte(input logic [7:0] b);
        case (m_mode)
            0: begin
                if (b == 8'hE0) m_mode = 1;
                else if (b == 8'hF0) m_mode = 2;
                else model_make(b);
            end
            1: begin
                if (b == 8'hF0) m_mode = 3;
                else if (b == 8'hE0) exp_seq++;
                else begin
                    model_make(b);
                    m_mode = 0;
                end
            end
            default: begin
                if (m_hv && b == m_hc) m_hv = 1'b0;
                m_mode = 0;
            end
        endcase
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_mode = 0;
        m_hv = 1'b0;
        m_hc = 8'h00;
    endtask

    // Present one byte for one cycle; caller sits at #1 after a posedge.
    task automatic send_raw(input logic [7:0] b);
        byteValid = 1'b1;
        byteData = b;
        @(posedge clk);
        #1;
        byteValid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        model_byte(b);
        send_raw(b);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_g(input logic [7:0] b);
        send(b);
        idle(1);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            idle(1);
            k++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        byteValid = 1'b0;
        idle(2);
        reset = 1'b0;
        model_reset();
    endtask

    // Monitor: pops expected commands whenever the DUT hands one over.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (overflow === 1'b1) ovf_seen++;
                if (seqError === 1'b1) seq_seen++;
                if (cmdValid === 1'b1 && cmdReady === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_cmd: got %0h expected none", cmdCode);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        check("cmd_code", {28'd0, cmdCode}, {28'd0, mon_exp});
                    end
                end
            end
        end
    end

    // Random consumer back-pressure during the random phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) cmdReady = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        idle(3);
        reset = 1'b0;
        check("rst_byteReady", byteReady, 1);
        check("rst_cmdValid", cmdValid, 0);
        check("rst_cmdCode", cmdCode, 0);
        check("rst_decCode", decCode, 0);
        check("rst_overflow", overflow, 0);
        check("rst_seqError", seqError, 0);
        mon_en = 1'b1;

        // Make/break with latency check, then re-press after release.
        cmdReady = 1'b1;
        send(8'h1E);
        check("lookup_byteReady", byteReady, 0);
        check("lookup_cmdValid", cmdValid, 0);
        idle(1);
        check("lat_cmdValid", cmdValid, 1);
        check("lat_cmdCode", cmdCode, 4'h1);
        idle(1);
        send_g(8'hF0);
        send_g(8'h1E);
        send_g(8'h1E);
        idle(3);

        // Byte presented during the lookup cycle is ignored.
        send(8'h2D);
        send_raw(8'h34);
        idle(3);

        // Extended key pressed twice then released.
        send_g(8'hE0);
        send_g(8'h75);
        send_g(8'hE0);
        send_g(8'h75);
        send_g(8'hE0);
        send_g(8'hF0);
        send_g(8'h75);
        idle(3);

        // Unmapped code: nothing queued, back to idle.
        send_g(8'h1C);
        check("unmapped_byteReady", byteReady, 1);
        check("unmapped_cmdValid", cmdValid, 0);
        drain("drain_directed");

        // Break prefix followed by silence.
        send(8'hF0);
        repeat (TO - 1) @(posedge clk);
        #1;
        check("timeout_early", seqError, 0);
        idle(1);
        check("timeout_pulse", seqError, 1);
        m_mode = 0;
        exp_seq++;
        idle(1);
        check("timeout_oneshot", seqError, 0);
        send_g(8'h16);
        idle(3);
        drain("drain_timeout");

        // Fill the FIFO and overflow once.
        do_reset();
        cmdReady = 1'b0;
        send_g(8'h2D);
        send_g(8'h34);
        send_g(8'h32);
        send_g(8'h43);
        send_g(8'h2B);
        idle(2);
        check("ovf_count", ovf_seen, exp_ovf);
        check("full_head", cmdCode, 4'h4);
        cmdReady = 1'b1;
        drain("drain_full");
        idle(1);
        check("full_empty", cmdValid, 0);

        // Reset landing on the lookup cycle with three entries queued.
        cmdReady = 1'b0;
        send_g(8'h2D);
        send_g(8'h34);
        send_g(8'h32);
        send(8'h43);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        model_reset();
        check("rstlk_cmdValid", cmdValid, 0);
        check("rstlk_byteReady", byteReady, 1);
        idle(3);
        check("rstlk_nopush", cmdValid, 0);

        // Randomized stream with random back-pressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            int k;
            k = 0;
            while (exp_q.size() >= DEPTH && k < 200) begin
                idle(1);
                k++;
            end
            if (k >= 200) begin
                n_checks++;
                n_errors++;
                $display("FAIL rand_stall: got %0d queued expected below %0d", exp_q.size(), DEPTH);
            end
            send(pool[$urandom_range(0, 13)]);
            idle($urandom_range(1, 4));
        end
        if (m_mode != 0) send_g(8'h1C);
        rand_ready = 1'b0;
        idle(1);
        cmdReady = 1'b1;
        drain("drain_random");
        idle(4);
        check("ovf_total", ovf_seen, exp_ovf);
        check("seq_total", seq_seen, exp_seq);
        check("end_cmdValid", cmdValid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
